// File: rtl/clk_div_delay_tune.sv
// rtl/clk_div_delay_tune.sv - per-channel delay-line tap tuning and bit-slip sequencer
module clk_div_delay_tune #(
    parameter int NUM_CH     = 2,
    parameter int TAP_W      = 8,
    parameter int SLIP_W     = 3,
    parameter int SETTLE_CYC = 4
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     START,
    input  logic [NUM_CH*TAP_W-1:0]  TARGET_TAP,
    input  logic [NUM_CH*SLIP_W-1:0] SLIP_CNT,
    input  logic [NUM_CH-1:0]        DELAY_LINE_OUT_OF_RANGE,
    output logic [NUM_CH-1:0]        DELAY_LINE_LOAD,
    output logic [NUM_CH-1:0]        DELAY_LINE_MOVE,
    output logic [NUM_CH-1:0]        DELAY_LINE_DIR,
    output logic [NUM_CH-1:0]        BIT_SLIP,
    output logic [NUM_CH*TAP_W-1:0]  CUR_TAP,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [NUM_CH-1:0]        ERR
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_MOVE, S_SLIP, S_NEXT, S_FINISH
    } state_t;

    state_t                    state_q, state_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic [3:0]                cnt_q, cnt_d;
    logic                      after_move_q, after_move_d;
    logic [NUM_CH*TAP_W-1:0]   target_q, target_d;
    logic [NUM_CH*SLIP_W-1:0]  slips_q, slips_d;
    logic [NUM_CH*TAP_W-1:0]   cur_tap_q, cur_tap_d;
    logic [NUM_CH-1:0]         err_q, err_d;
    logic [NUM_CH-1:0]         load_q, load_d;
    logic [NUM_CH-1:0]         move_q, move_d;
    logic [NUM_CH-1:0]         slip_q, slip_d;
    logic [NUM_CH-1:0]         dir_q, dir_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    // Current-channel views used by the sequencing decisions
    logic [NUM_CH-1:0]         ch_oh;
    logic [NUM_CH-1:0]         nxt_oh;
    logic [TAP_W-1:0]          cur_tgt;
    logic [TAP_W-1:0]          cur_tap;
    logic [SLIP_W-1:0]         cur_slip;
    logic                      cur_err;
    logic                      cur_oor;
    logic                      err_now;

    // Extract the selected channel's target, tap, slips and range flag
    always_comb begin
        ch_oh    = '0;
        cur_tgt  = '0;
        cur_tap  = '0;
        cur_slip = '0;
        cur_err  = 1'b0;
        cur_oor  = 1'b0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (ch_q == CH_W'(n)) begin
                ch_oh[n] = 1'b1;
                cur_tgt  = target_q[n*TAP_W +: TAP_W];
                cur_tap  = cur_tap_q[n*TAP_W +: TAP_W];
                cur_slip = slips_q[n*SLIP_W +: SLIP_W];
                cur_err  = err_q[n];
                cur_oor  = DELAY_LINE_OUT_OF_RANGE[n];
            end
        end
        // A range violation seen on the deciding cycle must already block the next move
        err_now = cur_err | (after_move_q & cur_oor);
    end

    // Next-state, datapath updates and next values of the registered outputs
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        cnt_d        = cnt_q;
        after_move_d = after_move_q;
        target_d     = target_q;
        slips_d      = slips_q;
        cur_tap_d    = cur_tap_q;
        err_d        = err_q;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    target_d  = TARGET_TAP;
                    slips_d   = SLIP_CNT;
                    cur_tap_d = '0;
                    err_d     = '0;
                    ch_d      = '0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d        = '0;
                after_move_d = 1'b0;
                state_d      = S_SETTLE;
            end
            S_SETTLE: begin
                if (after_move_q && cur_oor) begin
                    err_d = err_q | ch_oh;
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(SETTLE_CYC - 1)) begin
                    cnt_d        = '0;
                    after_move_d = 1'b0;
                    if ((cur_tap < cur_tgt) && !err_now) begin
                        state_d = S_MOVE;
                    end else if (cur_slip != '0) begin
                        state_d = S_SLIP;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_MOVE: begin
                for (int n = 0; n < NUM_CH; n++) begin
                    if (ch_oh[n] && (cur_tap_q[n*TAP_W +: TAP_W] != {TAP_W{1'b1}})) begin
                        cur_tap_d[n*TAP_W +: TAP_W] = cur_tap_q[n*TAP_W +: TAP_W] + TAP_W'(1);
                    end
                end
                after_move_d = 1'b1;
                cnt_d        = '0;
                state_d      = S_SETTLE;
            end
            S_SLIP: begin
                for (int n = 0; n < NUM_CH; n++) begin
                    if (ch_oh[n] && (slips_q[n*SLIP_W +: SLIP_W] != '0)) begin
                        slips_d[n*SLIP_W +: SLIP_W] = slips_q[n*SLIP_W +: SLIP_W] - SLIP_W'(1);
                    end
                end
                after_move_d = 1'b0;
                cnt_d        = '0;
                state_d      = S_SETTLE;
            end
            S_NEXT: begin
                cnt_d        = '0;
                after_move_d = 1'b0;
                if (ch_q == CH_W'(NUM_CH - 1)) begin
                    state_d = S_FINISH;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = S_SETTLE;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        nxt_oh = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            nxt_oh[n] = (ch_d == CH_W'(n));
        end

        // Outputs are registered from the next state so they line up with it
        load_d = (state_d == S_LOAD) ? {NUM_CH{1'b1}} : '0;
        move_d = (state_d == S_MOVE) ? nxt_oh : '0;
        slip_d = (state_d == S_SLIP) ? nxt_oh : '0;
        busy_d = (state_d != S_IDLE);
        dir_d  = busy_d ? nxt_oh : '0;
        done_d = (state_d == S_FINISH);
    end

    // State, datapath and output registers with asynchronous clear
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            ch_q         <= '0;
            cnt_q        <= '0;
            after_move_q <= 1'b0;
            target_q     <= '0;
            slips_q      <= '0;
            cur_tap_q    <= '0;
            err_q        <= '0;
            load_q       <= '0;
            move_q       <= '0;
            slip_q       <= '0;
            dir_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            cnt_q        <= cnt_d;
            after_move_q <= after_move_d;
            target_q     <= target_d;
            slips_q      <= slips_d;
            cur_tap_q    <= cur_tap_d;
            err_q        <= err_d;
            load_q       <= load_d;
            move_q       <= move_d;
            slip_q       <= slip_d;
            dir_q        <= dir_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign DELAY_LINE_LOAD = load_q;
    assign DELAY_LINE_MOVE = move_q;
    assign DELAY_LINE_DIR  = dir_q;
    assign BIT_SLIP        = slip_q;
    assign CUR_TAP         = cur_tap_q;
    assign ERR             = err_q;
    assign BUSY            = busy_q;
    assign DONE            = done_q;

endmodule

// File: tb/tb_clk_div_delay_tune.sv
// tb/tb_clk_div_delay_tune.sv - scoreboard bench for clk_div_delay_tune
module tb_clk_div_delay_tune;

    localparam int S = 2;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [15:0] TARGET_TAP;
    logic [5:0]  SLIP_CNT;
    logic [1:0]  OOR;
    logic [1:0]  LOAD, MOVE, DIR, SLIP;
    logic [15:0] CUR_TAP;
    logic        BUSY, DONE;
    logic [1:0]  ERR;

    logic        START7;
    logic [2:0]  TARGET7;
    logic [2:0]  SLIP7;
    logic        OOR7;
    logic        LOAD7, MOVE7, DIR7, SLIP7_O;
    logic [2:0]  CUR_TAP7;
    logic        BUSY7, DONE7;
    logic        ERR7;

    clk_div_delay_tune #(.NUM_CH(2), .TAP_W(8), .SLIP_W(3), .SETTLE_CYC(S)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .START(START),
        .TARGET_TAP(TARGET_TAP), .SLIP_CNT(SLIP_CNT),
        .DELAY_LINE_OUT_OF_RANGE(OOR),
        .DELAY_LINE_LOAD(LOAD), .DELAY_LINE_MOVE(MOVE),
        .DELAY_LINE_DIR(DIR), .BIT_SLIP(SLIP),
        .CUR_TAP(CUR_TAP), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    clk_div_delay_tune #(.NUM_CH(1), .TAP_W(3), .SLIP_W(3), .SETTLE_CYC(1)) u_dut7 (
        .CLK(CLK), .RST_N(RST_N), .START(START7),
        .TARGET_TAP(TARGET7), .SLIP_CNT(SLIP7),
        .DELAY_LINE_OUT_OF_RANGE(OOR7),
        .DELAY_LINE_LOAD(LOAD7), .DELAY_LINE_MOVE(MOVE7),
        .DELAY_LINE_DIR(DIR7), .BIT_SLIP(SLIP7_O),
        .CUR_TAP(CUR_TAP7), .BUSY(BUSY7), .DONE(DONE7), .ERR(ERR7)
    );

    typedef struct {
        logic [6:0] vec;
        int         cyc;
    } ev_t;

    ev_t q[$];
    int  n_chk = 0;
    int  n_err = 0;
    int  cyc   = 0;
    logic oor_arm = 1'b0;
    int  ch0_moves = 0;
    logic seen_ch1 = 1'b0;
    int  n7_moves = 0;
    int  n7_done  = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_ev(input logic [6:0] vec, input int t);
        ev_t e;
        e.vec = vec;
        e.cyc = t;
        q.push_back(e);
    endtask

    // Reference sequence: every pulse lands S+1 cycles after the previous
    // action; the last NEXT is followed by FINISH one cycle later.
    task automatic build_seq(input int tg0, input int tg1, input int sl0, input int sl1,
                             input int lim0, input int t0);
        int tg[2];
        int sl[2];
        int lim[2];
        int t;
        int mv;
        logic [1:0] oh;
        tg[0] = tg0; tg[1] = tg1; sl[0] = sl0; sl[1] = sl1;
        lim[0] = lim0; lim[1] = 1000;
        t = t0;
        push_ev({1'b0, 2'b11, 2'b00, 2'b00}, t);
        for (int ch = 0; ch < 2; ch++) begin
            oh = (ch == 0) ? 2'b01 : 2'b10;
            mv = (tg[ch] < lim[ch]) ? tg[ch] : lim[ch];
            for (int i = 0; i < mv; i++) begin
                t += S + 1;
                push_ev({1'b0, 2'b00, oh, 2'b00}, t);
            end
            for (int i = 0; i < sl[ch]; i++) begin
                t += S + 1;
                push_ev({1'b0, 2'b00, 2'b00, oh}, t);
            end
            t += S + 1;
        end
        t += 1;
        push_ev({1'b1, 6'b0}, t);
    endtask

    task automatic kick(input int tg0, input int tg1, input int sl0, input int sl1, input int lim0);
        TARGET_TAP = {8'(tg1), 8'(tg0)};
        SLIP_CNT   = {3'(sl1), 3'(sl0)};
        @(negedge CLK);
        build_seq(tg0, tg1, sl0, sl1, lim0, cyc + 1);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (q.size() == 0) break;
            @(negedge CLK);
        end
        check("drain", q.size(), 0);
        repeat (6) @(negedge CLK);
    endtask

    // Scoreboard monitor: every pulse or DONE must match the head of the queue
    always @(negedge CLK) begin
        logic [6:0] obs;
        ev_t e;
        obs = {DONE, LOAD, MOVE, SLIP};
        if (obs != 7'd0) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", {25'd0, obs}, 32'd0);
            end else begin
                e = q.pop_front();
                check("pulse", {25'd0, obs}, {25'd0, e.vec});
                check("pulse_cyc", cyc, e.cyc);
            end
        end
        if (MOVE != 2'b00) check("dir_on_move", {30'd0, DIR}, {30'd0, MOVE});
        if (MOVE[1]) seen_ch1 = 1'b1;
        if (oor_arm && MOVE[0]) begin
            ch0_moves++;
            if (ch0_moves == 2) OOR[0] = 1'b1;
        end
        if (MOVE7) n7_moves++;
        if (DONE7) n7_done++;
    end

    initial begin
        RST_N = 1'b0; START = 1'b0; TARGET_TAP = '0; SLIP_CNT = '0; OOR = '0;
        START7 = 1'b0; TARGET7 = '0; SLIP7 = '0; OOR7 = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_busy", {31'd0, BUSY}, 0);
        check("rst_done", {31'd0, DONE}, 0);
        check("rst_curtap", {16'd0, CUR_TAP}, 0);
        check("rst_err", {30'd0, ERR}, 0);
        check("rst_pulses", {24'd0, LOAD, MOVE, SLIP, DIR}, 0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Narrow tap counter: 7 moves, no wrap
        TARGET7 = 3'd7;
        START7  = 1'b1;
        @(negedge CLK);
        START7  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (n7_done != 0) break;
            @(negedge CLK);
        end
        repeat (4) @(negedge CLK);
        check("w3_done_cnt", n7_done, 1);
        check("w3_moves", n7_moves, 7);
        check("w3_curtap", {29'd0, CUR_TAP7}, 7);
        check("w3_busy", {31'd0, BUSY7}, 0);

        // Basic sequence
        kick(3, 5, 1, 0, 1000);
        wait_drain(300);
        check("basic_curtap", {16'd0, CUR_TAP}, 32'h0503);
        check("basic_err", {30'd0, ERR}, 0);
        check("basic_busy", {31'd0, BUSY}, 0);

        // Out-of-range after the second ch0 move
        oor_arm = 1'b1;
        ch0_moves = 0;
        kick(3, 5, 1, 0, 2);
        wait_drain(300);
        oor_arm = 1'b0;
        OOR = '0;
        check("oor_curtap", {16'd0, CUR_TAP}, 32'h0502);
        check("oor_err", {30'd0, ERR}, 32'h1);

        // All-zero targets and slips
        kick(0, 0, 0, 0, 1000);
        wait_drain(100);
        check("zero_err", {30'd0, ERR}, 0);
        check("zero_curtap", {16'd0, CUR_TAP}, 0);
        check("zero_busy", {31'd0, BUSY}, 0);

        // Second START and input changes while busy are ignored
        kick(2, 1, 2, 1, 1000);
        repeat (8) @(negedge CLK);
        TARGET_TAP = 16'h0707;
        SLIP_CNT   = 6'o77;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_drain(300);
        check("restart_curtap", {16'd0, CUR_TAP}, 32'h0102);

        // Reset in the middle of ch1 moves
        seen_ch1 = 1'b0;
        kick(1, 4, 0, 0, 1000);
        for (int i = 0; i < 200; i++) begin
            if (seen_ch1) break;
            @(negedge CLK);
        end
        check("ch1_move_seen", {31'd0, seen_ch1}, 1);
        #2 RST_N = 1'b0;
        #1;
        check("arst_busy", {31'd0, BUSY}, 0);
        check("arst_done", {31'd0, DONE}, 0);
        check("arst_curtap", {16'd0, CUR_TAP}, 0);
        check("arst_pulses", {24'd0, LOAD, MOVE, SLIP, DIR}, 0);
        q.delete();
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (40) @(negedge CLK);
        kick(1, 4, 0, 0, 1000);
        wait_drain(300);
        check("post_rst_curtap", {16'd0, CUR_TAP}, 32'h0401);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/clk_div_delay_tune.md
CLK_DIV_DELAY_TUNE -- requirements
Module: clk_div_delay_tune

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of clock-divider/delay-line channels controlled, legal range 1..4.
REQ-002 SHALL have parameter TAP_W, default 8: delay-line tap counter width.
REQ-003 SHALL have parameter SLIP_W, default 3: per-channel bit-slip count width.
REQ-004 SHALL have parameter SETTLE_CYC, default 4: idle cycles after every LOAD, MOVE or BIT_SLIP pulse, legal range 1..15.
REQ-005 SHALL have port CLK, input, 1 bit: the only clock; all logic is rising-edge.
REQ-006 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port START, input, 1 bit: one-cycle request to begin a tuning sequence.
REQ-008 SHALL have port TARGET_TAP, input, NUM_CH*TAP_W bits: per-channel target tap count, channel n at [n*TAP_W +: TAP_W].
REQ-009 SHALL have port SLIP_CNT, input, NUM_CH*SLIP_W bits: per-channel number of BIT_SLIP pulses.
REQ-010 SHALL have port DELAY_LINE_OUT_OF_RANGE, input, NUM_CH bits: per-channel range flag from the delay line.
REQ-011 SHALL have ports DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIR and BIT_SLIP, each output, NUM_CH bits: per-channel delay-line and divider control.
REQ-012 SHALL have port CUR_TAP, output, NUM_CH*TAP_W bits: per-channel count of applied tap moves.
REQ-013 SHALL have ports BUSY, DONE and ERR: BUSY and DONE output 1 bit; ERR output NUM_CH bits, per-channel out-of-range error.

Function
REQ-014 SHALL implement states IDLE, LOAD, SETTLE, MOVE, SLIP, NEXT and FINISH.
REQ-015 In IDLE, START=1 SHALL capture TARGET_TAP and SLIP_CNT into internal registers, clear ERR and CUR_TAP, set channel index to 0, and go to LOAD; later input changes have no effect until the next START.
REQ-016 START SHALL be ignored when BUSY=1.
REQ-017 LOAD SHALL assert DELAY_LINE_LOAD on all NUM_CH bits for exactly one cycle, then go to SETTLE.
REQ-018 SETTLE SHALL hold all pulse outputs low for exactly SETTLE_CYC cycles, then go to the next action for the current channel, checked in this order:
  - MOVE if CUR_TAP < target and the channel has no error.
  - Otherwise SLIP if slips remain.
  - Otherwise NEXT.
REQ-019 MOVE SHALL assert DELAY_LINE_MOVE for one cycle on the current channel bit only, with DELAY_LINE_DIR=1 on that bit, increment that channel's CUR_TAP by 1 (visible the following cycle), then go to SETTLE.
REQ-020 DELAY_LINE_DIR SHALL be 1 for the current channel whenever BUSY=1, and 0 otherwise.
REQ-021 If DELAY_LINE_OUT_OF_RANGE of the current channel is 1 in any SETTLE cycle following a MOVE, the block SHALL set ERR for that channel and make no further MOVE pulses for it; its slips still execute.
REQ-022 CUR_TAP SHALL saturate at 2^TAP_W-1; it SHALL never wrap to 0.
REQ-023 SLIP SHALL assert BIT_SLIP for one cycle on the current channel, decrement the remaining slip count, then go to SETTLE.
REQ-024 NEXT SHALL take one cycle: increment the channel index and go to SETTLE; if the index is NUM_CH-1, it SHALL go to FINISH instead.
REQ-025 A target of 0 and a slip count of 0 SHALL give zero pulses for that channel; the channel still costs the SETTLE and NEXT cycles.
REQ-026 FINISH SHALL assert DONE for exactly one cycle, then go to IDLE.
REQ-027 BUSY SHALL be 1 in every state except IDLE.
REQ-028 At most one of LOAD, MOVE or BIT_SLIP SHALL be nonzero in any cycle, except that LOAD is on all channels.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 RST_N=0 SHALL, asynchronously, clear all state and outputs: state to IDLE, CUR_TAP 0, ERR 0, BUSY 0, DONE 0, all pulse outputs 0 and DIR 0.
REQ-031 RST_N=0 during a sequence SHALL abort it; no DONE is produced, and the next START restarts the sequence from LOAD.

Verification
REQ-032 NUM_CH=2, SETTLE_CYC=2, TARGET={5,3}, SLIP={0,1}, START:
  - One LOAD pulse (2'b11).
  - Then 3 MOVE pulses on ch0 and 1 BIT_SLIP on ch0, each 3 cycles apart.
  - Then 5 MOVE pulses on ch1.
  - Then DONE for one cycle.
  - Final CUR_TAP={5,3}, ERR=0.
REQ-033 Same setup with OUT_OF_RANGE[0] forced to 1 after the 2nd ch0 MOVE: ch0 stops at CUR_TAP=2, ch0 slip still occurs, ch1 completes, ERR=2'b01, DONE pulses.
REQ-034 TARGET={0,0}, SLIP={0,0}: exactly one LOAD pulse, no MOVE or BIT_SLIP pulses, DONE pulses, BUSY returns to 0.
REQ-035 START pulsed again during BUSY: no restart and no change to the pulse sequence; a single DONE.
REQ-036 RST_N low for 1 cycle during ch1 moves: all outputs 0 immediately and no DONE; the next START gives a full sequence beginning with LOAD.
REQ-037 TAP_W=3, TARGET=7, NUM_CH=1: exactly 7 MOVE pulses, CUR_TAP=7, no wrap.
